// File: rtl/seven2binary_if.sv
// Display capture bus: multiplexed digit enable/segments in, decoded digit state and update stream out.
// The slave modport is the decoder; the master modport is the display driver plus update consumer.
interface seven2binary_if #(
  parameter int NUM_DIGITS = 4
);
  logic [NUM_DIGITS-1:0]   AN;
  logic [0:6]              SEV;
  logic [4*NUM_DIGITS-1:0] DIGITS;
  logic [NUM_DIGITS-1:0]   DIG_VALID;
  logic [NUM_DIGITS-1:0]   DIG_ERR;
  logic                    UPD_VALID;
  logic                    UPD_READY;
  logic [2:0]              UPD_DIGIT;
  logic [3:0]              UPD_BIN;
  logic                    UPD_ERR;
  logic                    OVERFLOW;

  modport slave (
    input  AN, SEV, UPD_READY,
    output DIGITS, DIG_VALID, DIG_ERR,
    output UPD_VALID, UPD_DIGIT, UPD_BIN, UPD_ERR, OVERFLOW
  );

  modport master (
    output AN, SEV, UPD_READY,
    input  DIGITS, DIG_VALID, DIG_ERR,
    input  UPD_VALID, UPD_DIGIT, UPD_BIN, UPD_ERR, OVERFLOW
  );
endinterface

// File: rtl/seven2binary.sv
// Seven-segment capture decoder: commits a digit STABLE_CYCLES-1 edges after its pattern is first captured.
// One-deep registered update stream; an unaccepted event is overwritten and OVERFLOW sticks.
module seven2binary #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  seven2binary_if.slave bus
);

  localparam int                 CNT_W      = $clog2(STABLE_CYCLES + 2);
  localparam logic [CNT_W-1:0]   CNT_SAT    = CNT_W'(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_COMMIT = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

  // {valid, err, code}
  function automatic logic [5:0] decode(input logic [0:6] seg);
    logic [5:0] r;
    case (seg)
      7'b1111110: r = {2'b10, 4'h0};
      7'b0110000: r = {2'b10, 4'h1};
      7'b1101101: r = {2'b10, 4'h2};
      7'b1111001: r = {2'b10, 4'h3};
      7'b0110011: r = {2'b10, 4'h4};
      7'b1011011: r = {2'b10, 4'h5};
      7'b1011111: r = {2'b10, 4'h6};
      7'b1110000: r = {2'b10, 4'h7};
      7'b1111111: r = {2'b10, 4'h8};
      7'b1110011: r = {2'b10, 4'h9};
      7'b1110111: r = {2'b10, 4'hA};
      7'b0011111: r = {2'b10, 4'hB};
      7'b1001110: r = {2'b10, 4'hC};
      7'b0111101: r = {2'b10, 4'hD};
      7'b1001111: r = {2'b10, 4'hE};
      7'b1000111: r = {2'b10, 4'hF};
      7'b0000000: r = 6'b00_0000;
      default:    r = 6'b01_0000;
    endcase
    return r;
  endfunction

  logic [NUM_DIGITS-1:0]   cap_an_q,  cap_an_d;
  logic [0:6]              cap_sev_q, cap_sev_d;
  logic [CNT_W-1:0]        cnt_q,     cnt_d;
  logic [4*NUM_DIGITS-1:0] digits_q,  digits_d;
  logic [NUM_DIGITS-1:0]   dig_vld_q, dig_vld_d;
  logic [NUM_DIGITS-1:0]   dig_err_q, dig_err_d;
  logic                    upd_vld_q, upd_vld_d;
  logic [2:0]              upd_dig_q, upd_dig_d;
  logic [3:0]              upd_bin_q, upd_bin_d;
  logic                    upd_err_q, upd_err_d;
  logic                    ovf_q,     ovf_d;

  logic                    one_hot;
  logic                    same;
  logic                    commit;
  logic                    new_evt;
  logic [5:0]              dec;
  logic [5:0]              stored;
  logic [2:0]              sel_idx;

  // Capture and stability window
  always_comb begin
    cap_an_d  = bus.AN;
    cap_sev_d = bus.SEV;
    one_hot   = $onehot(bus.AN);
    same      = (bus.AN == cap_an_q) && (bus.SEV == cap_sev_q);
    cnt_d     = cnt_q;
    commit    = 1'b0;
    if (!one_hot) begin
      cnt_d = '0;
    end else if (!same) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_SAT) begin
      cnt_d  = cnt_q + CNT_ONE;
      commit = (cnt_q == CNT_COMMIT);
    end
  end

  // Per-digit state and event detection
  always_comb begin
    dec       = decode(bus.SEV);
    digits_d  = digits_q;
    dig_vld_d = dig_vld_q;
    dig_err_d = dig_err_q;
    sel_idx   = '0;
    stored    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bus.AN[i]) begin
        sel_idx = 3'(i);
        stored  = {dig_vld_q[i], dig_err_q[i], digits_q[4*i +: 4]};
      end
    end
    new_evt = commit && (stored != dec);
    if (commit) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (bus.AN[i]) begin
          digits_d[4*i +: 4] = dec[3:0];
          dig_vld_d[i]       = dec[5];
          dig_err_d[i]       = dec[4];
        end
      end
    end
  end

  // Update stream: a new event always wins over the pending one
  always_comb begin
    upd_vld_d = upd_vld_q;
    upd_dig_d = upd_dig_q;
    upd_bin_d = upd_bin_q;
    upd_err_d = upd_err_q;
    ovf_d     = ovf_q;
    if (new_evt) begin
      upd_vld_d = 1'b1;
      upd_dig_d = sel_idx;
      upd_bin_d = dec[3:0];
      upd_err_d = dec[4];
      if (upd_vld_q && !bus.UPD_READY) begin
        ovf_d = 1'b1;
      end
    end else if (upd_vld_q && bus.UPD_READY) begin
      upd_vld_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cap_an_q  <= '0;
      cap_sev_q <= '0;
      cnt_q     <= '0;
      digits_q  <= '0;
      dig_vld_q <= '0;
      dig_err_q <= '0;
      upd_vld_q <= 1'b0;
      upd_dig_q <= '0;
      upd_bin_q <= '0;
      upd_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      cap_an_q  <= cap_an_d;
      cap_sev_q <= cap_sev_d;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      dig_vld_q <= dig_vld_d;
      dig_err_q <= dig_err_d;
      upd_vld_q <= upd_vld_d;
      upd_dig_q <= upd_dig_d;
      upd_bin_q <= upd_bin_d;
      upd_err_q <= upd_err_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.DIGITS    = digits_q;
  assign bus.DIG_VALID = dig_vld_q;
  assign bus.DIG_ERR   = dig_err_q;
  assign bus.UPD_VALID = upd_vld_q;
  assign bus.UPD_DIGIT = upd_dig_q;
  assign bus.UPD_BIN   = upd_bin_q;
  assign bus.UPD_ERR   = upd_err_q;
  assign bus.OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_seven2binary.sv
// Directed bench for seven2binary: expected update events are queued at stimulus time and
// popped by a monitor on each accepted handshake; register state is checked at fixed edges.
module tb_seven2binary;

  logic clk;
  logic rst_n;

  seven2binary_if #(.NUM_DIGITS(4)) bus ();

  seven2binary #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] dig;
    logic [3:0] bin;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] d, input logic [3:0] b, input logic e);
    exp_t x;
    x.dig = d;
    x.bin = b;
    x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] sev);
    bus.AN  = an;
    bus.SEV = sev;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {5'b0, bus.DIGITS, bus.DIG_VALID, bus.DIG_ERR, bus.UPD_VALID,
            bus.UPD_DIGIT, bus.UPD_BIN, bus.UPD_ERR, bus.OVERFLOW};
  endfunction

  // Monitor: every accepted event must match the oldest queued expectation
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (rst_n && bus.UPD_VALID && bus.UPD_READY) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got digit=%0d bin=%0h err=%0b expected none",
                   bus.UPD_DIGIT, bus.UPD_BIN, bus.UPD_ERR);
        end else begin
          x = exp_q.pop_front();
          if (bus.UPD_DIGIT !== x.dig || bus.UPD_BIN !== x.bin || bus.UPD_ERR !== x.err) begin
            errors++;
            $display("FAIL event: got digit=%0d bin=%0h err=%0b expected digit=%0d bin=%0h err=%0b",
                     bus.UPD_DIGIT, bus.UPD_BIN, bus.UPD_ERR, x.dig, x.bin, x.err);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.UPD_READY = 1'b0;
    drive(4'b0, 7'b0);

    // Reset with random inputs
    repeat (5) begin
      @(posedge clk);
      #1;
      bus.AN        = 4'($urandom);
      bus.SEV       = 7'($urandom);
      bus.UPD_READY = 1'($urandom);
    end
    chk("reset_outs", all_outs(), 32'h0);
    drive(4'b0, 7'b0);
    bus.UPD_READY = 1'b1;
    rst_n = 1'b1;
    step(3);
    chk("post_reset_outs", all_outs(), 32'h0);

    // Legal commit of 2 on digit 0
    push_exp(3'd0, 4'h2, 1'b0);
    drive(4'b0001, 7'b1101101);
    step(3);
    chk("legal_no_early", bus.UPD_VALID, 1'b0);
    step(1);
    chk("legal_digit0", bus.DIGITS[3:0], 4'h2);
    chk("legal_dig_valid", bus.DIG_VALID, 4'b0001);
    chk("legal_upd_valid", bus.UPD_VALID, 1'b1);
    chk("legal_upd_digit", bus.UPD_DIGIT, 3'd0);
    chk("legal_upd_bin", bus.UPD_BIN, 4'h2);
    step(20);
    chk("legal_hold_quiet", bus.UPD_VALID, 1'b0);

    // Glitch: 7 held 3 edges then changed to 8
    drive(4'b0100, 7'b1110000);
    step(3);
    push_exp(3'd2, 4'h8, 1'b0);
    drive(4'b0100, 7'b1111111);
    step(1);
    chk("glitch_no_commit_valid", bus.UPD_VALID, 1'b0);
    chk("glitch_no_commit_dv", bus.DIG_VALID, 4'b0001);
    step(2);
    chk("glitch_not_yet", bus.UPD_VALID, 1'b0);
    step(1);
    chk("glitch_digit2", bus.DIGITS[11:8], 4'h8);
    chk("glitch_dig_valid", bus.DIG_VALID, 4'b0101);
    step(2);

    // Illegal then blank on digit 1
    push_exp(3'd1, 4'h0, 1'b1);
    drive(4'b0010, 7'b1000000);
    step(4);
    chk("illegal_dig_err", bus.DIG_ERR, 4'b0010);
    chk("illegal_dig_valid1", bus.DIG_VALID[1], 1'b0);
    chk("illegal_upd_err", bus.UPD_ERR, 1'b1);
    chk("illegal_upd_bin", bus.UPD_BIN, 4'h0);
    push_exp(3'd1, 4'h0, 1'b0);
    drive(4'b0010, 7'b0000000);
    step(4);
    chk("blank_dig_err", bus.DIG_ERR, 4'b0000);
    chk("blank_upd_valid", bus.UPD_VALID, 1'b1);
    chk("blank_upd_err", bus.UPD_ERR, 1'b0);
    chk("blank_upd_bin", bus.UPD_BIN, 4'h0);
    step(2);

    // Reassert unchanged pattern: commits without an event
    drive(4'b0000, 7'b0);
    step(2);
    drive(4'b0001, 7'b1101101);
    step(4);
    chk("recommit_no_event", bus.UPD_VALID, 1'b0);
    step(2);

    // Backpressure and overflow
    bus.UPD_READY = 1'b0;
    drive(4'b0001, 7'b1011011);
    step(4);
    chk("bp_first_valid", bus.UPD_VALID, 1'b1);
    chk("bp_first_bin", bus.UPD_BIN, 4'h5);
    chk("bp_no_ovf_yet", bus.OVERFLOW, 1'b0);
    push_exp(3'd1, 4'hA, 1'b0);
    drive(4'b0010, 7'b1110111);
    step(4);
    chk("bp_overflow", bus.OVERFLOW, 1'b1);
    chk("bp_pending_digit", bus.UPD_DIGIT, 3'd1);
    chk("bp_pending_bin", bus.UPD_BIN, 4'hA);
    chk("bp_still_valid", bus.UPD_VALID, 1'b1);
    bus.UPD_READY = 1'b1;
    step(1);
    chk("bp_drop_valid", bus.UPD_VALID, 1'b0);

    // Non-one-hot enable never commits
    drive(4'b0011, 7'b1111111);
    step(10);
    chk("nonhot_no_event", bus.UPD_VALID, 1'b0);
    chk("nonhot_dig_valid", bus.DIG_VALID, 4'b0111);
    chk("nonhot_digits", bus.DIGITS, 16'h08A5);

    // Reset mid-window
    drive(4'b1000, 7'b0110011);
    step(2);
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", all_outs(), 32'h0);
    step(1);
    rst_n = 1'b1;
    step(3);
    chk("midrst_no_early", bus.UPD_VALID, 1'b0);
    chk("midrst_digits_zero", bus.DIGITS, 16'h0);
    push_exp(3'd3, 4'h4, 1'b0);
    step(1);
    chk("midrst_digit3", bus.DIGITS[15:12], 4'h4);
    chk("midrst_dig_valid", bus.DIG_VALID, 4'b1000);
    chk("midrst_ovf_cleared", bus.OVERFLOW, 1'b0);
    step(3);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven2binary.md
# seven2binary

Seven-segment capture decoder for the calculator display path. It is the receive-side counterpart of the binary-to-seven-segment encoder.
- Samples a time-multiplexed display bus (one-hot digit enable plus segment lines a..g), waits for each digit's pattern to be stable, and decodes it back to a 4-bit hex value.
- Holds a per-digit value/valid/error register and reports every change on a one-deep valid/ready update stream.
- Used for display loopback checking and for reading the display state back into control logic.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is committed (>=2).
- CLK  in  1  sole clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- AN  in  NUM_DIGITS  digit enable, active-high, one-hot when a digit is driven; synchronous to CLK.
- SEV  in  [0:6]  segments, active-high; SEV[0]=a … SEV[6]=g.
- DIGITS  out  4*NUM_DIGITS  decoded value of digit i at [4i+3:4i].
- DIG_VALID  out  NUM_DIGITS  digit i holds a legal decoded code.
- DIG_ERR  out  NUM_DIGITS  digit i's last committed pattern was illegal.
- UPD_VALID  out  1  update event pending.
- UPD_READY  in  1  consumer accepts the event.
- UPD_DIGIT  out  3  index of the updated digit.
- UPD_BIN  out  4  new value; 0 when UPD_ERR or blank.
- UPD_ERR  out  1  update was an illegal pattern.
- OVERFLOW  out  1  sticky; an unaccepted event was overwritten.

## Operation
- Capture register CAP <= {AN, SEV} on every edge. Counter CNT counts consecutive edges with unchanged CAP and saturates at STABLE_CYCLES+1.
- When the newly captured value differs from the old CAP, CNT <= 1.
- If the new AN is not exactly one-hot (zero or multiple bits), CNT <= 0 and nothing commits while it persists.
- Commit happens on the edge where CNT would advance STABLE_CYCLES-1 -> STABLE_CYCLES. It occurs exactly once per stable window. Digit index = position of the AN bit.
- Decode table (abcdefg): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1110011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Commit results:
  - Table match: DIGITS[i] = code, DIG_VALID[i]=1, DIG_ERR[i]=0.
  - Blank (SEV=0000000): DIGITS[i]=0, DIG_VALID[i]=0, DIG_ERR[i]=0.
  - Any other pattern: DIGITS[i]=0, DIG_VALID[i]=0, DIG_ERR[i]=1.
- Event rule: a commit whose {DIGITS[i], DIG_VALID[i], DIG_ERR[i]} differs from the stored value loads the UPD_* register and sets UPD_VALID=1. A commit that matches the stored value produces no event.
- Handshake:
  - UPD_VALID && UPD_READY at an edge with no new event: UPD_VALID <= 0.
  - New event while UPD_VALID=1 and UPD_READY=0: the new event overwrites the pending one and OVERFLOW <= 1.
  - New event on the same edge as an accept: the new event loads, UPD_VALID stays 1, OVERFLOW unchanged.
- OVERFLOW clears only on reset.

## Timing
- Reset (async assert, sync-safe deassert): CAP=0, CNT=0, and every output is 0 (DIGITS, DIG_VALID, DIG_ERR, UPD_VALID, UPD_DIGIT, UPD_BIN, UPD_ERR, OVERFLOW).
- Inputs set before edge k and held: CAP loads at edge k. Digit registers and the UPD_* outputs update at edge k+STABLE_CYCLES-1, i.e. edge k+3 at default.
- Any input change inside the window restarts it, so a pattern held fewer than STABLE_CYCLES edges never commits.
- Holding a pattern indefinitely produces one commit only. Deasserting and reasserting the same pattern commits again, but raises no event because the stored state is unchanged.
- Reset asserted mid-window discards the window and all state. After deassertion the next window starts from CNT=0.
- UPD_* outputs are registered. Zero combinational path from UPD_READY to any output.

## Test plan
- Reset: drive RST_N=0 with random inputs -> all outputs 0. Release -> outputs stay 0 until the first commit.
- Legal commit: AN=0001, SEV=1101101 held from edge 0 -> at edge 3, DIGITS[3:0]=2, DIG_VALID=0001, UPD_VALID=1, UPD_DIGIT=0, UPD_BIN=2. Holding 20 more cycles -> no further event.
- Glitch reject: AN=0100, SEV=1110000 held 3 edges then SEV=1111111 -> no commit at edge 3. Commit of 8 on digit 2 occurs 4 edges after the change.
- Illegal/blank: AN=0010 with SEV=1000000 -> DIG_ERR=0010, DIG_VALID[1]=0, UPD_ERR=1. Then SEV=0000000 -> DIG_ERR[1]=0 and an event with UPD_BIN=0, UPD_ERR=0.
- Backpressure: UPD_READY=0, commit digit 0=5 then digit 1=A -> OVERFLOW=1, pending event is digit 1/A. Raise UPD_READY -> UPD_VALID drops next edge.
- Non-one-hot and reset mid-window: AN=0011 held 10 cycles -> no commit. A legal digit with RST_N pulsed at edge 2 -> no commit, all outputs 0, and a fresh 4-edge window is needed.
